// File: rtl/ipv_pkg.sv
// ipv_pkg: shared IPV constants and state encoding for the serializer and reducer sides
package ipv_pkg;
  localparam int IPV_K_MAX = 8;
  localparam int IPV_CNT_W = 3;
  typedef enum logic {IPV_IDLE, IPV_SHIFT} ipv_state_e;
endpackage

// File: rtl/ipv_serializer_if.sv
// ipv_serializer_if: parallel vote-vector handshake in, serial IPV bit handshake out
interface ipv_serializer_if #(parameter int K = 4);
  logic [K-1:0] vov_in;
  logic vov_valid, vov_ready, ipv_out, ipv_valid, ipv_last, out_ready;
  modport master (output vov_in, vov_valid, out_ready, input vov_ready, ipv_out, ipv_valid, ipv_last);
  modport slave (input vov_in, vov_valid, out_ready, output vov_ready, ipv_out, ipv_valid, ipv_last);
endinterface

// File: rtl/ipv_hold_slot.sv
// ipv_hold_slot: one-entry registered holding buffer for a pending vote vector
module ipv_hold_slot #(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] in_data,
  output logic         full,
  output logic [W-1:0] data
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (push) begin
      full <= 1'b1;
      data <= in_data;
    end else if (pop) full <= 1'b0;
endmodule

// File: rtl/ipv_serializer.sv
// ipv_serializer: K-bit vote vector to LSB-first serial IPV stream
// define IPV_SER_HOLD_EN to add a one-entry hold slot giving gapless back-to-back frames
module ipv_serializer
  import ipv_pkg::*;
#(parameter int K = 4) (
  input logic clk,
  input logic rst_n,
  ipv_serializer_if.slave bus
);
  ipv_state_e state;
  logic [K-1:0] sr, ld_data;
  logic [IPV_CNT_W-1:0] cnt;
  logic xfer, last_x, accept, load;
  assign xfer = state == IPV_SHIFT && bus.out_ready;
  assign last_x = xfer && cnt == IPV_CNT_W'(K - 1);
  assign accept = bus.vov_valid && bus.vov_ready;
  assign bus.ipv_out = sr[0];
  assign bus.ipv_valid = state == IPV_SHIFT;
  assign bus.ipv_last = state == IPV_SHIFT && cnt == IPV_CNT_W'(K - 1);
`ifdef IPV_SER_HOLD_EN
  logic hold_full;
  logic [K-1:0] hold_data;
  ipv_hold_slot #(.W(K)) u_hold (
    .clk(clk), .rst_n(rst_n),
    .push(accept && state == IPV_SHIFT && !last_x),
    .pop(last_x && hold_full),
    .in_data(bus.vov_in), .full(hold_full), .data(hold_data)
  );
  assign bus.vov_ready = !hold_full;
  // the hold slot is only ever occupied while shifting, so idle loads always come from vov_in
  assign load = (state == IPV_IDLE && accept) || (last_x && (hold_full || accept));
  assign ld_data = hold_full ? hold_data : bus.vov_in;
`else
  assign bus.vov_ready = state == IPV_IDLE;
  assign load = accept;
  assign ld_data = bus.vov_in;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IPV_IDLE;
      sr <= '0;
      cnt <= '0;
    end else if (load) begin
      state <= IPV_SHIFT;
      sr <= ld_data;
      cnt <= '0;
    end else if (xfer) begin
      sr <= sr >> 1;
      cnt <= last_x ? '0 : cnt + IPV_CNT_W'(1);
      state <= last_x ? IPV_IDLE : IPV_SHIFT;
    end
endmodule

// File: tb/tb_ipv_serializer.sv
// tb_ipv_serializer: directed-vector bench for ipv_serializer (K=4 and K=8 instances)
module tb_ipv_serializer;
`ifdef IPV_SER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vec = 0;
  int err = 0;
  always #5 clk = ~clk;
  ipv_serializer_if #(.K(4)) b4 ();
  ipv_serializer_if #(.K(8)) b8 ();
  ipv_serializer #(.K(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  ipv_serializer #(.K(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vec++;
    if ({b4.ipv_valid, b4.ipv_out, b4.ipv_last, b4.vov_ready} !== 4'b0001) begin
      err++;
      $display("FAIL in_reset got %b exp 0001", {b4.ipv_valid, b4.ipv_out, b4.ipv_last, b4.vov_ready});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vec++;
      if ({b4.ipv_valid, b4.ipv_out, b4.ipv_last, b4.vov_ready} !== 4'b0001) begin
        err++;
        $display("FAIL reset_idle c=%0d got %b exp 0001", c, {b4.ipv_valid, b4.ipv_out, b4.ipv_last, b4.vov_ready});
      end
    end
  endtask

  task automatic test_single;
    logic [3:0] v;
    logic [3:0] e;
    v = 4'b1011;
    @(negedge clk);
    b4.vov_in = v;
    b4.vov_valid = 1'b1;
    b4.out_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      b4.vov_valid = 1'b0;
      e = {c <= 4, c <= 4 ? v[(c - 1) & 3] : 1'b0, c == 4, HOLD || c == 5};
      vec++;
      if ({b4.ipv_valid, b4.ipv_out, b4.ipv_last, b4.vov_ready} !== e) begin
        err++;
        $display("FAIL single c=%0d got %b exp %b", c, {b4.ipv_valid, b4.ipv_out, b4.ipv_last, b4.vov_ready}, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] tx [2];
    logic [9:0] ev, eo, el;
    int idx;
    logic acc;
    tx[0] = 4'b0110;
    tx[1] = 4'b1001;
    ev = HOLD ? 10'b0011111111 : 10'b0111101111;
    eo = HOLD ? 10'b0010010110 : 10'b0100100110;
    el = HOLD ? 10'b0010001000 : 10'b0100001000;
    idx = 0;
    b4.out_ready = 1'b1;
    @(negedge clk);
    b4.vov_in = tx[0];
    b4.vov_valid = 1'b1;
    acc = b4.vov_ready;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (acc) idx++;
      vec++;
      if ({b4.ipv_valid, b4.ipv_out, b4.ipv_last} !== {ev[c - 1], eo[c - 1], el[c - 1]}) begin
        err++;
        $display("FAIL back_to_back c=%0d got %b exp %b", c, {b4.ipv_valid, b4.ipv_out, b4.ipv_last}, {ev[c - 1], eo[c - 1], el[c - 1]});
      end
      b4.vov_valid = idx < 2;
      b4.vov_in = tx[idx & 1];
      acc = b4.vov_valid && b4.vov_ready;
    end
    b4.vov_valid = 1'b0;
    vec++;
    if (idx != 2) begin
      err++;
      $display("FAIL back_to_back_accepts got %0d exp 2", idx);
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] v, rx;
    logic [6:0] ro, rv, rl;
    int n;
    v = 4'b1100;
    ro = 7'b0110000;
    rv = 7'b0111111;
    rl = 7'b0100000;
    rx = '0;
    n = 0;
    @(negedge clk);
    b4.vov_in = v;
    b4.vov_valid = 1'b1;
    b4.out_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      b4.vov_valid = 1'b0;
      b4.out_ready = !(c == 2 || c == 3);
      vec++;
      if ({b4.ipv_valid, b4.ipv_out, b4.ipv_last} !== {rv[c - 1], ro[c - 1], rl[c - 1]}) begin
        err++;
        $display("FAIL backpressure c=%0d got %b exp %b", c, {b4.ipv_valid, b4.ipv_out, b4.ipv_last}, {rv[c - 1], ro[c - 1], rl[c - 1]});
      end
      if (b4.ipv_valid && b4.out_ready) begin
        rx[n & 3] = b4.ipv_out;
        n++;
      end
    end
    b4.out_ready = 1'b1;
    vec++;
    if (rx !== v || n != 4) begin
      err++;
      $display("FAIL backpressure_frame got %b/%0d bits exp %b/4 bits", rx, n, v);
    end
  endtask

  task automatic test_mid_reset;
    logic [3:0] v;
    logic [3:0] e;
    b4.out_ready = 1'b1;
    @(negedge clk);
    b4.vov_in = 4'b1110;
    b4.vov_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      b4.vov_valid = 1'b0;
    end
    vec++;
    if ({b4.ipv_valid, b4.ipv_out} !== 2'b11) begin
      err++;
      $display("FAIL pre_reset_bit2 got %b exp 11", {b4.ipv_valid, b4.ipv_out});
    end
    rst_n = 1'b0;
    #1;
    vec++;
    if ({b4.ipv_valid, b4.ipv_out, b4.ipv_last, b4.vov_ready} !== 4'b0001) begin
      err++;
      $display("FAIL mid_reset got %b exp 0001", {b4.ipv_valid, b4.ipv_out, b4.ipv_last, b4.vov_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    v = 4'b0001;
    b4.vov_in = v;
    b4.vov_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      b4.vov_valid = 1'b0;
      e = {c <= 4, c <= 4 ? v[(c - 1) & 3] : 1'b0, c == 4, HOLD || c == 5};
      vec++;
      if ({b4.ipv_valid, b4.ipv_out, b4.ipv_last, b4.vov_ready} !== e) begin
        err++;
        $display("FAIL post_reset c=%0d got %b exp %b", c, {b4.ipv_valid, b4.ipv_out, b4.ipv_last, b4.vov_ready}, e);
      end
    end
  endtask

  task automatic test_k8;
    logic [7:0] tx [2];
    logic [7:0] rx;
    int n, f, sent;
    tx[0] = 8'hA5;
    tx[1] = 8'h3C;
    rx = '0;
    n = 0;
    f = 0;
    sent = 0;
    for (int c = 0; c < 80 && f < 2; c++) begin
      @(negedge clk);
      b8.vov_valid = sent < 2;
      b8.vov_in = tx[sent & 1];
      b8.out_ready = (c % 3) != 1;
      if (b8.ipv_valid && b8.out_ready) begin
        vec++;
        if (b8.ipv_last !== (n == 7)) begin
          err++;
          $display("FAIL k8_last frame=%0d bit=%0d got %b exp %b", f, n, b8.ipv_last, n == 7);
        end
        rx[n & 7] = b8.ipv_out;
        if (n == 7) begin
          vec++;
          if (rx !== tx[f & 1]) begin
            err++;
            $display("FAIL k8_reduce frame=%0d got %h exp %h", f, rx, tx[f & 1]);
          end
          f++;
          n = 0;
        end else n++;
      end
      if (b8.vov_valid && b8.vov_ready) sent++;
    end
    b8.vov_valid = 1'b0;
    vec++;
    if (f != 2) begin
      err++;
      $display("FAIL k8_timeout frames got %0d exp 2", f);
    end
  endtask

  initial begin
    b4.vov_in = '0;
    b4.vov_valid = 1'b0;
    b4.out_ready = 1'b1;
    b8.vov_in = '0;
    b8.vov_valid = 1'b0;
    b8.out_ready = 1'b1;
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_mid_reset;
    test_k8;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ipv_serializer.md
Name: ipv_serializer

Overview:
- Transmit-side counterpart of the IPV reduction path: accepts a K-bit vote vector (vov) over a valid/ready handshake and emits it as a serial IPV bit stream, LSB first, with per-bit valid/ready.
- A downstream reducer assembling K serial bits reconstructs the original vector exactly.
- Sits between the vote-vector producer and the serial IPV link.

Parameters:
- K, 4, vector width / bits per frame; legal range 2..8.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- vov_in  input  K  parallel vector to serialize
- vov_valid  input  1  vov_in valid
- vov_ready  output  1  block can accept vov_in this cycle
- ipv_out  output  1  serial bit, registered
- ipv_valid  output  1  ipv_out valid
- ipv_last  output  1  high with the K-th (MSB) bit of a frame
- out_ready  input  1  downstream accepts ipv_out this cycle

Behaviour:
- Reset (async, rst_n=0): shift register=0, bit counter=0, busy=0, hold slot empty.
- Output values during reset: ipv_out=0, ipv_valid=0, ipv_last=0, vov_ready=1.
- Reset asserted mid-frame: in-flight and held vectors are discarded; no partial frame resumes.
- States:
  - IDLE (busy=0): vov_ready=1. On vov_valid&&vov_ready, load shift register with vov_in, set counter=0, go to SHIFT.
  - SHIFT (busy=1): ipv_valid=1, ipv_out = current shift-register bit 0.
- Latency: first bit is visible the cycle after acceptance.
- Bit transfer: ipv_valid&&out_ready. On transfer, shift right by one and increment the counter.
- While out_ready=0: ipv_out, ipv_valid and ipv_last hold stable.
- ipv_last = ipv_valid && (counter==K-1).
- Frame end: a transfer with counter==K-1 clears the counter to 0 (wrap); busy clears unless a next vector is available (see Optional Feature).
- Without the feature, vov_ready=!busy:
  - the last-bit transfer at cycle T gives ready at T+1, acceptance at T+1 and first bit at T+2;
  - this is exactly one bubble cycle between frames.
- vov_valid while vov_ready=0 is ignored; the producer must hold the vector.
- No combinational path from out_ready to vov_ready in the base build.
- Counter is 3 bits wide for all K≤8; values ≥K are never reached.

Optional Feature:
- Macro: IPV_SER_HOLD_EN.
- When defined, a one-entry hold slot is added:
  - vov_ready = !hold_full, registered.
  - A vector accepted while busy goes into the hold slot.
  - On a last-bit transfer with the hold slot full, the held vector loads into the shift register in the same cycle. Its bit 0 is valid the next cycle, so there is no bubble, and the hold slot empties.
  - Acceptance in the same cycle as a last-bit transfer: if the hold slot is empty, the vector goes directly into the shift register.
- Not defined: no hold slot; base behaviour with one bubble cycle per frame.

Decomposition:
- Shared package ipv_pkg holds:
  - IPV_K_MAX=8 and IPV_CNT_W=3;
  - the state enum {IPV_IDLE, IPV_SHIFT};
  - these are reused by the reducer side.
- Optional sub-module ipv_hold_slot (1-entry valid/ready register), instantiated only under IPV_SER_HOLD_EN.
- Counter and shift register stay in the top module.

Test Plan:
- Reset then idle (K=4) -> ipv_valid=0, ipv_out=0, vov_ready=1 for 10 cycles.
- Single frame 4'b1011 accepted at cycle 0, out_ready=1 -> ipv_out=1,1,0,1 at cycles 1-4; ipv_last only at cycle 4; vov_ready low at cycles 1-4.
- Back-to-back frames 4'b0110, 4'b1001 with vov_valid held:
  - base build: bits 0,1,1,0, one bubble cycle, then 1,0,0,1;
  - IPV_SER_HOLD_EN build: eight consecutive valid bits, no bubble.
- Backpressure: frame 4'b1100 with out_ready low on cycles 2-3 -> ipv_out/ipv_last stable across the stall; the sequence is still 0,0,1,1 with ipv_last on the 4th transferred bit.
- Reset mid-frame after 2 of 4 bits -> outputs return to reset values immediately; next frame 4'b0001 serializes cleanly from bit 0.
- K=8, vector 8'hA5, looped back into the reducer -> reducer output equals 8'hA5; the counter wraps 7->0 without glitching ipv_last.
